// File: rtl/sq_sig_gen_if.sv
// Configuration, control and status bundle of the NCO square-wave generator.
// The bench drives through the master modport; the generator sits on the slave side.
interface sq_sig_gen_if #(
  parameter int PHASE_W = 32,
  parameter int CNT_W   = 32
);
  logic [PHASE_W-1:0] ftw_in;
  logic [PHASE_W-1:0] duty_in;
  logic [CNT_W-1:0]   burst_len_in;
  logic               cfg_load;
  logic               cfg_busy;
  logic               start;
  logic               stop;
  logic               sig_out;
  logic               running;
  logic [CNT_W-1:0]   period_cnt;
  logic               done;

  modport master (
    output ftw_in, duty_in, burst_len_in, cfg_load, start, stop,
    input  cfg_busy, sig_out, running, period_cnt, done
  );

  modport slave (
    input  ftw_in, duty_in, burst_len_in, cfg_load, start, stop,
    output cfg_busy, sig_out, running, period_cnt, done
  );
endinterface

// File: rtl/sq_sig_gen.sv
// Phase-accumulator square-wave generator with duty threshold, counted bursts
// and period-boundary (glitch-free) reconfiguration.
module sq_sig_gen #(
  parameter int PHASE_W = 32,
  parameter int CNT_W   = 32
) (
  input  logic        clk_100M,
  input  logic        rst,
  sq_sig_gen_if.slave bus
);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] RUN      = 2'd1;
  localparam logic [1:0] STOPPING = 2'd2;

  logic [1:0]         state;
  logic [PHASE_W-1:0] phase;
  logic [PHASE_W-1:0] act_ftw;
  logic [PHASE_W-1:0] act_duty;
  logic [CNT_W-1:0]   act_burst;
  logic [PHASE_W-1:0] pend_ftw;
  logic [PHASE_W-1:0] pend_duty;
  logic [CNT_W-1:0]   pend_burst;
  logic [CNT_W-1:0]   period_cnt;
  logic               cfg_busy;
  logic               sig_out;
  logic               done;

  logic [PHASE_W:0]   phase_sum;
  logic               wrap;
  logic [CNT_W-1:0]   cnt_next;
  logic               burst_end;
  logic               finish;

  // A period boundary is the carry out of the accumulator. Stop with ftw = 0
  // ends at once since no carry would ever come; stop on a wrap cycle ends there.
  always_comb begin
    phase_sum = {1'b0, phase} + {1'b0, act_ftw};
    wrap      = phase_sum[PHASE_W];
    cnt_next  = period_cnt + CNT_W'(1);
    burst_end = wrap && (act_burst != '0) && (cnt_next == act_burst);
    finish    = 1'b0;
    if (state == RUN)
      finish = burst_end || (bus.stop && (wrap || (act_ftw == '0)));
    else if (state == STOPPING)
      finish = wrap;
  end

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      act_ftw    <= '0;
      act_duty   <= '0;
      act_burst  <= '0;
      pend_ftw   <= '0;
      pend_duty  <= '0;
      pend_burst <= '0;
      period_cnt <= '0;
      cfg_busy   <= 1'b0;
      sig_out    <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (bus.cfg_load) begin
        pend_ftw   <= bus.ftw_in;
        pend_duty  <= bus.duty_in;
        pend_burst <= bus.burst_len_in;
      end
      case (state)
        IDLE: begin
          phase    <= '0;
          sig_out  <= 1'b0;
          cfg_busy <= 1'b0;
          // A set left pending by an ftw = 0 stop is flushed here; a fresh load wins.
          if (bus.cfg_load) begin
            act_ftw   <= bus.ftw_in;
            act_duty  <= bus.duty_in;
            act_burst <= bus.burst_len_in;
          end else if (cfg_busy) begin
            act_ftw   <= pend_ftw;
            act_duty  <= pend_duty;
            act_burst <= pend_burst;
          end
          if (bus.start) begin
            state      <= RUN;
            period_cnt <= '0;
          end
        end
        RUN, STOPPING: begin
          if (wrap)
            period_cnt <= cnt_next;
          if (finish) begin
            state   <= IDLE;
            done    <= 1'b1;
            phase   <= '0;
            sig_out <= 1'b0;
          end else begin
            phase   <= phase_sum[PHASE_W-1:0];
            sig_out <= (phase < act_duty);
            if (state == RUN && bus.stop)
              state <= STOPPING;
          end
          // Burst compare above used the old set; the new one governs the next period.
          if (wrap && cfg_busy) begin
            act_ftw   <= pend_ftw;
            act_duty  <= pend_duty;
            act_burst <= pend_burst;
          end
          if (bus.cfg_load)
            cfg_busy <= 1'b1;
          else if (wrap)
            cfg_busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cfg_busy   = cfg_busy;
  assign bus.sig_out    = sig_out;
  assign bus.running    = (state == RUN) || (state == STOPPING);
  assign bus.period_cnt = period_cnt;
  assign bus.done       = done;

endmodule

// File: tb/tb_sq_sig_gen.sv
// Directed bench for sq_sig_gen: inputs change 1 ns after each rising edge,
// outputs are sampled at the same point, so a sample shows the last edge's result.
module tb_sq_sig_gen;

  localparam logic [31:0] F1   = 32'h0800_0000;
  localparam logic [31:0] F2   = 32'h1000_0000;
  localparam logic [31:0] F4M  = 32'h0A3D_70A4;
  localparam logic [31:0] HALF = 32'h8000_0000;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sq_sig_gen_if #(.PHASE_W(32), .CNT_W(32)) bus ();

  sq_sig_gen #(.PHASE_W(32), .CNT_W(32)) dut (
    .clk_100M (clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_cfg(input logic [31:0] f, input logic [31:0] d, input logic [31:0] b);
    bus.ftw_in       = f;
    bus.duty_in      = d;
    bus.burst_len_in = b;
    bus.cfg_load     = 1'b1;
    tick();
    bus.cfg_load     = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
  endtask

  logic        rec_sig  [0:80];
  logic        rec_busy [0:80];
  logic [31:0] rec_pc   [0:80];
  int          rises[$];
  int          falls[$];
  int          rise_exp [4] = '{2, 34, 50, 66};
  int          fall_exp [4] = '{18, 42, 58, 74};

  initial begin
    logic [63:0] ph;
    logic        exp_sig;
    logic        prev;
    int          pulses;
    int          done_cnt;
    int          high_cnt;

    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.ftw_in = '0;
    bus.duty_in = '0;
    bus.burst_len_in = '0;
    bus.cfg_load = 1'b0;
    bus.start = 1'b0;
    bus.stop = 1'b0;
    tick();
    tick();
    check("rst_sig", bus.sig_out, 0);
    check("rst_running", bus.running, 0);
    check("rst_done", bus.done, 0);
    check("rst_busy", bus.cfg_busy, 0);
    check("rst_pcnt", bus.period_cnt, 0);
    rst = 1'b0;

    // Basic continuous run: 32-cycle period, 16 high / 16 low, first high on RUN cycle 2
    load_cfg(F1, HALF, 0);
    check("idle_load_busy", bus.cfg_busy, 0);
    check("idle_load_running", bus.running, 0);
    pulse_start();
    for (int k = 1; k <= 320; k++) begin
      ph = ((64'(k) - 64'd2) * 64'(F1)) & 64'hFFFF_FFFF;
      exp_sig = (k >= 2) && (ph[31:0] < HALF);
      check("basic_sig", bus.sig_out, exp_sig);
      tick();
    end
    check("basic_pcnt_320", bus.period_cnt, 10);
    check("basic_running", bus.running, 1);

    // Stop on cycle 5 of period 11: 27 more cycles to the wrap, then done
    for (int i = 0; i < 4; i++) tick();
    pulse_stop();
    check("stopping_running", bus.running, 1);
    done_cnt = 0;
    for (int k = 326; k < 353; k++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    check("stop_no_early_done", done_cnt, 0);
    check("stop_done", bus.done, 1);
    check("stop_running", bus.running, 0);
    check("stop_sig", bus.sig_out, 0);
    check("stop_pcnt", bus.period_cnt, 11);
    tick();
    check("stop_done_once", bus.done, 0);
    check("stop_pcnt_hold", bus.period_cnt, 11);
    pulse_stop();
    check("idle_stop_ignored_run", bus.running, 0);
    check("idle_stop_ignored_done", bus.done, 0);

    // Burst of 4: four pulses, done 128 cycles after RUN entry
    load_cfg(F1, HALF, 4);
    check("burst_load_busy", bus.cfg_busy, 0);
    pulse_start();
    pulses = 0;
    prev = 1'b0;
    done_cnt = 0;
    for (int k = 1; k <= 128; k++) begin
      if (bus.sig_out && !prev) pulses++;
      prev = bus.sig_out;
      if (bus.done) done_cnt++;
      tick();
    end
    check("burst_no_early_done", done_cnt, 0);
    check("burst_done", bus.done, 1);
    check("burst_running", bus.running, 0);
    check("burst_sig", bus.sig_out, 0);
    check("burst_pulses", pulses, 4);
    check("burst_pcnt", bus.period_cnt, 4);
    tick();
    check("burst_done_once", bus.done, 0);
    check("burst_pcnt_hold", bus.period_cnt, 4);

    // Reconfigure at phase 0x30000000: current period stays 32, then 16-cycle periods
    load_cfg(F1, HALF, 0);
    pulse_start();
    rises.delete();
    falls.delete();
    rec_sig[0] = 1'b0;
    for (int k = 1; k <= 80; k++) begin
      rec_sig[k]  = bus.sig_out;
      rec_busy[k] = bus.cfg_busy;
      rec_pc[k]   = bus.period_cnt;
      if (rec_sig[k] && !rec_sig[k-1]) rises.push_back(k);
      if (!rec_sig[k] && rec_sig[k-1]) falls.push_back(k);
      bus.cfg_load = 1'b0;
      if (k == 7) begin
        bus.ftw_in       = F2;
        bus.duty_in      = HALF;
        bus.burst_len_in = '0;
        bus.cfg_load     = 1'b1;
      end
      tick();
    end
    bus.cfg_load = 1'b0;
    check("reconf_busy_k7", rec_busy[7], 0);
    check("reconf_busy_k8", rec_busy[8], 1);
    check("reconf_busy_k32", rec_busy[32], 1);
    check("reconf_busy_k33", rec_busy[33], 0);
    check("reconf_pcnt_k48", rec_pc[48], 1);
    check("reconf_pcnt_k49", rec_pc[49], 2);
    check("reconf_rise_count", rises.size(), 4);
    check("reconf_fall_count", falls.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < rises.size()) check("reconf_rise_pos", rises[i], rise_exp[i]);
      if (i < falls.size()) check("reconf_fall_pos", falls[i], fall_exp[i]);
    end
    pulse_stop();
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    check("reconf_stop_done", done_cnt, 1);
    check("reconf_stop_idle", bus.running, 0);

    // ftw = 0: stop ends the run directly
    load_cfg(0, HALF, 0);
    pulse_start();
    for (int i = 0; i < 3; i++) tick();
    check("ftw0_running", bus.running, 1);
    check("ftw0_sig_high", bus.sig_out, 1);
    pulse_stop();
    check("ftw0_done", bus.done, 1);
    check("ftw0_running_off", bus.running, 0);
    check("ftw0_sig_off", bus.sig_out, 0);

    // Burst completion and stop on the same wrap cycle: one done
    load_cfg(F1, HALF, 1);
    pulse_start();
    for (int k = 1; k < 32; k++) tick();
    pulse_stop();
    check("both_done", bus.done, 1);
    check("both_running", bus.running, 0);
    check("both_pcnt", bus.period_cnt, 1);
    tick();
    check("both_done_once", bus.done, 0);

    // Reset during period 2 of a 4-period burst
    load_cfg(F1, HALF, 4);
    pulse_start();
    for (int k = 1; k < 40; k++) tick();
    check("pre_rst_running", bus.running, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_sig", bus.sig_out, 0);
    check("midrst_running", bus.running, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_busy", bus.cfg_busy, 0);
    check("midrst_pcnt", bus.period_cnt, 0);
    done_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.done) done_cnt++;
      tick();
    end
    check("midrst_no_done", done_cnt, 0);
    pulse_start();
    high_cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.sig_out) high_cnt++;
      tick();
    end
    check("cleared_cfg_running", bus.running, 1);
    check("cleared_cfg_sig_low", high_cnt, 0);
    check("cleared_cfg_pcnt", bus.period_cnt, 0);
    pulse_stop();
    check("cleared_cfg_stop_done", bus.done, 1);

    // 4 MHz loopback word, loaded together with start
    bus.ftw_in       = F4M;
    bus.duty_in      = HALF;
    bus.burst_len_in = '0;
    bus.cfg_load     = 1'b1;
    bus.start        = 1'b1;
    tick();
    bus.cfg_load     = 1'b0;
    bus.start        = 1'b0;
    check("lb_running", bus.running, 1);
    check("lb_busy", bus.cfg_busy, 0);
    check("lb_sig_k1", bus.sig_out, 0);
    tick();
    check("lb_sig_k2_new_duty", bus.sig_out, 1);
    for (int k = 2; k <= 10000; k++) tick();
    check("lb_pcnt_10000", bus.period_cnt, 400);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sq_sig_gen.md
Name: sq_sig_gen

Overview:
- Numerically controlled square-wave generator on the 100 MHz fabric clock. It is the stimulus source for the frequency meter.
- A 32-bit phase accumulator sets the frequency. A phase threshold sets the duty cycle.
- Supports continuous and counted-burst modes. Configuration updates are glitch-free and take effect only at period boundaries.
- Output feeds a pin or loops back into the meter input for self-test. Output frequency is ftw * 100e6 / 2^32.

Parameters:
- PHASE_W, 32, phase accumulator / tuning word / duty word width.
- CNT_W, 32, width of burst length and period counter.

Ports:
- clk_100M  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- ftw_in  in  PHASE_W  tuning word (phase increment per clock).
- duty_in  in  PHASE_W  high-time threshold; sig_out is high while phase < duty.
- burst_len_in  in  CNT_W  periods per burst; 0 = continuous.
- cfg_load  in  1  one-cycle strobe; captures ftw_in, duty_in, burst_len_in into the pending set.
- cfg_busy  out  1  high while a pending set awaits application.
- start  in  1  one-cycle strobe; starts generation.
- stop  in  1  one-cycle strobe; ends generation at the next period boundary.
- sig_out  out  1  generated square wave, registered.
- running  out  1  high in RUN or STOPPING.
- period_cnt  out  CNT_W  periods completed since the last start; wraps modulo 2^CNT_W.
- done  out  1  one-cycle pulse when generation ends, by burst completion or stop.

Behaviour:
- Reset (rst=1 at a clk_100M edge):
  - State goes to IDLE. phase, period_cnt, pending and active sets are cleared.
  - sig_out, running, done and cfg_busy are all 0.
  - Reset applies in any state and aborts any burst immediately with no done pulse.
- Active set (ftw, duty, burst_len) drives generation. Pending set is written by cfg_load.
- cfg_load in IDLE: written to both the pending and active sets in the same cycle; cfg_busy stays 0.
- cfg_load in RUN or STOPPING:
  - Written to the pending set; cfg_busy goes to 1 the next cycle.
  - Pending is copied to active in the wrap cycle; cfg_busy returns to 0 the cycle after.
  - A second cfg_load before the wrap overwrites the pending set (last write wins).
- Wrap = carry out of phase + ftw (active).
- IDLE:
  - phase = 0, sig_out = 0.
  - start -> RUN next cycle with phase = 0 and period_cnt = 0. stop is ignored.
- RUN:
  - Each cycle phase <= phase + ftw, modulo 2^PHASE_W.
  - sig_out <= (phase < duty), using the current phase register (one-cycle latency).
  - The first sig_out high appears on the second cycle of RUN when duty > 0.
  - On a wrap: period_cnt increments.
  - If burst_len != 0 and the new period_cnt equals burst_len -> IDLE, done = 1 for one cycle, sig_out = 0.
  - Any cfg set that becomes active at this wrap applies from the next period. Its burst_len is compared starting at the following wrap.
  - stop -> STOPPING. start is ignored.
- STOPPING:
  - Same stepping as RUN.
  - At the next wrap -> IDLE with done pulse; period_cnt includes the finished period.
  - If active ftw = 0, stop goes from RUN directly to IDLE with done the next cycle, because no wrap will ever occur.
- Simultaneous events:
  - Burst completion on the same cycle as stop: single transition to IDLE with a single done pulse.
  - cfg_load and start in IDLE on the same cycle: the new configuration is used for the started run.
- Duty limits:
  - duty = 0: sig_out is constantly 0 while running.
  - duty >= 2^PHASE_W - ftw + 1 with small ftw: near-100% high. No special casing.
- Period length is floor or ceil of 2^PHASE_W / ftw cycles (jitter of one clock, inherent to an NCO).
- period_cnt holds its value in IDLE until the next start.

Test Plan:
- Basic run:
  - Stimulus: ftw=0x08000000, duty=0x80000000, burst=0, cfg_load then start.
  - Required: period of exactly 32 cycles, 16 high / 16 low; first high on the 2nd RUN cycle; period_cnt=10 after 320 cycles.
- Burst:
  - Stimulus: burst_len=4, same ftw/duty, start.
  - Required: exactly 4 high pulses; done pulses once 128 cycles after RUN entry; then running=0 and sig_out=0; period_cnt holds 4.
- Mid-period reconfiguration:
  - Stimulus: running at ftw=0x08000000; cfg_load ftw=0x10000000 at phase 0x30000000.
  - Required: cfg_busy=1 until the wrap; the current period stays 32 cycles, then 16-cycle periods; no runt pulse.
- Stop:
  - Stimulus: stop at cycle 5 of a period.
  - Required: the period completes (27 more cycles), then done and IDLE.
  - Stimulus: ftw=0, then stop.
  - Required: IDLE with done the next cycle.
- Reset mid-burst:
  - Stimulus: rst for 1 cycle during the 2nd of 4 burst periods.
  - Required: all outputs 0 the next cycle; no done pulse.
  - Stimulus: a subsequent start.
  - Required: the cleared configuration yields ftw=0, so sig_out stays 0.
- Loopback:
  - Stimulus: ftw=0x0A3D70A4 (4 MHz) driving the meter.
  - Required: meter ratio cnt_x*1e8/cnt_s = 4.000e6 +/- 1 count.
